// File: rtl/alu_defs_pkg.sv
// Shared encodings for the ALU control decoder and the mult/div sequencer.
package alu_defs_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_NOR     = 4'b0100;
    localparam logic [3:0] ALU_SLTU    = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SRL     = 4'b1001;
    localparam logic [3:0] ALU_SRA     = 4'b1010;
    localparam logic [3:0] ALU_PASS_HI = 4'b1011;
    localparam logic [3:0] ALU_PASS_LO = 4'b1100;

    // ALUOp from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type funct field values
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Step counter width for a WIDTH-step iteration
    function automatic int md_cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 unsigned iterative datapath shared by multiply (shift-add) and
// divide (restoring). Operands are magnitudes; sign handling is upstream.
// hi_nxt/lo_nxt are the register values after the current step, so the
// owner can capture the final result on the same edge as the last step.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    // acc: partial product high half / partial remainder
    // low: multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    // One multiply or divide step computed from the current registers
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_sh   = {acc_q, low_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        // The true difference is below 2^WIDTH whenever it is kept, so the
        // low WIDTH bits are exact even if div_sh overflowed WIDTH bits.
        div_diff = div_sh[WIDTH-1:0] - b_q;
        if (div_q) begin
            hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_nxt = {low_q[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], low_q[WIDTH-1:1]};
        end
    end

    // Load operands on start, advance one step per enable
    always_comb begin
        acc_d = acc_q;
        low_d = low_q;
        b_d   = b_q;
        div_d = div_q;
        if (load) begin
            acc_d = '0;
            low_d = a_mag;
            b_d   = b_mag;
            div_d = div_mode;
        end else if (step) begin
            acc_d = hi_nxt;
            low_d = lo_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            low_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            low_q <= low_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decode plus the multi-cycle mult/div sequencer owning HI/LO.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   MD_IDLE | no mult/div in flight; mthi/mtlo and new starts accepted
//   MD_BUSY | iterating, one radix-2 step per cycle, pipeline stalled
module alu_ctrl_md
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       ALUControl,
    output logic             md_stall,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = md_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             op_div_q, op_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             bzero_q, bzero_d;

    logic             start, md_start;
    logic             is_md_op, op_signed, sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod;

    // Combinational ALU operation decode
    always_comb begin
        ALUControl = ALU_AND;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_OR:  ALUControl = ALU_OR;
            default: begin
                if (funct[5:2] == 4'b1001) begin
                    case (funct[1:0])
                        2'b00:   ALUControl = ALU_AND;
                        2'b01:   ALUControl = ALU_OR;
                        2'b10:   ALUControl = ALU_XOR;
                        default: ALUControl = ALU_NOR;
                    endcase
                end else begin
                    case (funct)
                        F_ADD, F_ADDU: ALUControl = ALU_ADD;
                        F_SUB, F_SUBU: ALUControl = ALU_SUB;
                        F_SLT:         ALUControl = ALU_SLT;
                        F_SLTU:        ALUControl = ALU_SLTU;
                        F_SLL:         ALUControl = ALU_SLL;
                        F_SRL:         ALUControl = ALU_SRL;
                        F_SRA:         ALUControl = ALU_SRA;
                        F_MFHI:        ALUControl = ALU_PASS_HI;
                        F_MFLO:        ALUControl = ALU_PASS_LO;
                        default:       ALUControl = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    // Start qualification and operand magnitudes for the iterative core
    always_comb begin
        // done_q blocks the instruction still sitting in EX on its
        // completion cycle from being taken as a fresh request.
        start     = valid && (ALUOp == ALUOP_RTYPE) && !flush &&
                    (state_q == MD_IDLE) && !done_q;
        is_md_op  = (funct[5:2] == 4'b0110);
        md_start  = start && is_md_op;
        op_signed = !funct[0];
        sign_a    = op_signed && src_a[WIDTH-1];
        sign_b    = op_signed && src_b[WIDTH-1];
        a_mag     = sign_a ? -src_a : src_a;
        b_mag     = sign_b ? -src_b : src_b;
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode (funct[1]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .hi_nxt   (core_hi),
        .lo_nxt   (core_lo)
    );

    // Sequencer next state, HI/LO updates and result sign correction
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        op_div_d  = op_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        bzero_d   = bzero_q;
        core_load = md_start;
        core_step = 1'b0;
        prod      = {core_hi, core_lo};

        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d  = MD_BUSY;
                    cnt_d    = '0;
                    op_div_d = funct[1];
                    // mult: one sign for the whole product
                    // div: quotient sign from both, remainder follows dividend
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = funct[1] ? sign_a : (sign_a ^ sign_b);
                    bzero_d  = (src_b == '0);
                end else if (start && (funct == F_MTHI)) begin
                    hi_d = src_a;
                end else if (start && (funct == F_MTLO)) begin
                    lo_d = src_a;
                end
            end
            default: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = MD_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        if (op_div_q) begin
                            // The core already leaves the dividend in the
                            // remainder for a zero divisor; the quotient is
                            // forced so the signed case is not negated.
                            lo_d = bzero_q ? '1 : (neg_lo_q ? -core_lo : core_lo);
                            hi_d = neg_hi_q ? -core_hi : core_hi;
                        end else begin
                            if (neg_lo_q) begin
                                prod = -{core_hi, core_lo};
                            end
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
            end
        endcase
    end

    // Sequencer and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            op_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            op_div_q <= op_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
        end
    end

    assign md_stall = md_start || (state_q == MD_BUSY);
    assign md_done  = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/alu_ctrl_md.md
# alu_ctrl_md

Second-generation ALU control for the MIPS datapath.
- Decodes `ALUOp`/`funct` into a widened 4-bit `ALUControl` that covers the full R-type integer set.
- Adds an iterative multiply/divide sequencer that owns the HI/LO registers.
- Sits in EX alongside the ALU and raises a stall toward the hazard unit while a multi-cycle operation runs.
- Legacy 3-bit codes keep their values, zero-extended.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be even, 8 or more.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ALUOp`  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 OR (ori)
- `funct`  in  6  R-type function field
- `valid`  in  1  a real instruction is present in EX this cycle
- `flush`  in  1  abort any in-flight mult/div
- `src_a`, `src_b`  in  WIDTH  rs/rt operands
- `ALUControl`  out  4  ALU operation select (combinational)
- `md_stall`  out  1  hold IF/ID/EX
- `md_done`  out  1  one-cycle pulse: HI/LO just updated by mult/div
- `hi`, `lo`  out  WIDTH  HI/LO register contents

## Operation
ALUControl encodings:
- Logic and arithmetic: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLTU 0101, SUB 0110, SLT 0111.
- Shifts: SLL 1000, SRL 1001, SRA 1010.
- HI/LO pass-through: PASS_HI 1011, PASS_LO 1100.

Decode:
- ALUOp 00 → ADD. ALUOp 01 → SUB. ALUOp 11 → OR.
- ALUOp 10 uses `funct`:
  - add/addu (100000/100001) → ADD; sub/subu (100010/100011) → SUB.
  - and/or/xor/nor (1001xx) → AND/OR/XOR/NOR.
  - slt 101010 → SLT; sltu 101011 → SLTU.
  - sll 000000 → SLL; srl 000010 → SRL; sra 000011 → SRA.
  - mfhi 010000 → PASS_HI; mflo 010010 → PASS_LO.
  - Any other funct, including mult/div/mthi/mtlo → 0000.

Start condition:
- `start` = `valid & ALUOp==10 & !flush & state==IDLE & !md_done`.
- The `!md_done` term prevents the instruction still held in EX during its completion cycle from restarting.

Mult/div FSM (IDLE, BUSY):
- **IDLE → BUSY** on `start` with funct mult 011000, multu 011001, div 011010 or divu 011011.
  - Latch magnitudes: abs for signed ops, raw for unsigned.
  - Latch the result signs.
  - Set the counter to 0.
- **BUSY**: one radix-2 step per cycle (shift-add multiply, restoring divide); counter increments.
- **BUSY → IDLE** on the step with counter == WIDTH-1.
  - Write HI/LO with sign-corrected results.
  - mult: {HI,LO} = 2·WIDTH-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divisor 0 (div or divu): LO = all ones, HI = dividend, same latency.
- mthi 010001 / mtlo 010011 with `start`: HI or LO ← `src_a` at the next edge; no stall, no `md_done`.
- `flush` while BUSY: go to IDLE at the next edge; HI/LO unchanged; no `md_done`.
- `flush` in the same cycle as a start request: the start is suppressed.
- `md_stall` = (`start` & mult/div funct) | state==BUSY.
- `valid` is ignored while BUSY (the pipeline is held).
- `rst`: state IDLE, counter 0, HI 0, LO 0, `md_done` 0, `md_stall` 0. This applies mid-operation too, discarding the result.

## Timing
- `ALUControl` is purely combinational, zero latency.
- Mult/div accepted at cycle 0:
  - BUSY during cycles 1..WIDTH.
  - `md_stall` high in cycles 0..WIDTH (WIDTH+1 cycles).
  - HI/LO new values and `md_done`=1 in cycle WIDTH+1; `md_stall` is low in that cycle.
- mfhi/mflo issued in the `md_done` cycle or later sees the new value.
- mthi/mtlo: new value visible 1 cycle after issue.
- The next mult/div can start in cycle WIDTH+2.

## Structure
- Package `alu_defs_pkg`:
  - ALUControl encodings, ALUOp codes, funct constants.
  - FSM state type, counter width `$clog2(WIDTH)`.
- Sub-module `md_iter_core`:
  - WIDTH-parametrised iterative datapath: partial product/remainder, quotient registers, one step per enable.
  - Sign correction is performed in the top level.
- FSM, decode, and HI/LO registers live in `alu_ctrl_md`.

## Test plan
WIDTH=32 for all scenarios.
1. Decode sweep:
   - ALUOp=10 with funct 100010 → 0110, 101011 → 0101, 000011 → 1010, 111111 → 0000.
   - ALUOp=00 → 0010; ALUOp=11 → 0001.
2. mult with `src_a`=FFFFFFFE, `src_b`=00000003 → `md_stall` high 33 cycles; `md_done` in cycle 33; HI=FFFFFFFF, LO=FFFFFFFA.
   - multu with the same operands → HI=00000002, LO=FFFFFFFA.
3. div with −7 / 2 → LO=FFFFFFFD, HI=FFFFFFFF.
   - divu with 7 / 0 → LO=FFFFFFFF, HI=00000007, same 33-cycle stall.
4. mult started, `flush` in cycle 10:
   - `md_stall` low from cycle 11, no `md_done`, HI/LO keep their prior values.
   - Repeat with `rst` instead of `flush` → HI=LO=0.
5. mthi with `src_a`=00001234 → HI=00001234 next cycle, no stall.
   - mfhi → ALUControl=1011.
   - mult held in EX with `valid` during the `md_done` cycle → no restart.
